// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: turns start/length/direction
// commands into one RAM strobe per word, with a valid/ready write stream and a read strobe.
module ram_burst_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W:0]   req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              done,
  output logic              ram_CS,
  output logic              ram_WE,
  output logic [ADDR_W-1:0] ram_Addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FIN} state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_L = 1;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cur;
  logic [ADDR_W:0]     r_rem;
  logic                r_cs;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic                r_rd_valid;
  logic [ADDR_W-1:0]   r_rd_addr;

  logic                w_more;
  logic                w_accept;
  logic                w_wr_fire;
  logic                w_rd_fire;
  logic                w_issue;

  always_comb begin
    w_more    = (r_rem != '0);
    w_accept  = req_valid && (r_state == S_IDLE);
    w_wr_fire = (r_state == S_WRITE) && w_more && wr_valid;
    w_rd_fire = (r_state == S_READ) && w_more;
    w_issue   = w_wr_fire || w_rd_fire;
  end

  // WRITE/READ linger one cycle after the final issue so that FIN (and done)
  // lands in the cycle after the last RAM strobe is on the pins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (req_len == '0)  w_next = S_FIN;
          else if (req_write) w_next = S_WRITE;
          else                w_next = S_READ;
        end
      end
      S_WRITE: if (!w_more) w_next = S_FIN;
      S_READ:  if (!w_more) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_rem      <= '0;
      r_cs       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cur <= req_addr;
        r_rem <= req_len;
      end else if (w_issue) begin
        r_cur <= r_cur + ONE_A;
        r_rem <= r_rem - ONE_L;
      end
      r_cs <= w_issue;
      r_we <= w_wr_fire;
      if (w_issue)   r_addr <= r_cur;
      if (w_wr_fire) r_din  <= wr_data;
      // RAM output register adds one cycle, so read results trail the strobe by one.
      r_rd_valid <= r_cs && !r_we;
      r_rd_addr  <= r_addr;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign wr_ready   = (r_state == S_WRITE) && w_more;
  assign done       = (r_state == S_FIN);
  assign ram_CS     = r_cs;
  assign ram_WE     = r_we;
  assign ram_Addr   = r_addr;
  assign ram_dataIn = r_din;
  assign rd_valid   = r_rd_valid;
  assign rd_addr    = r_rd_addr;
  assign rd_data    = ram_dataOut;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: a RAM model plus a transaction-level expectation queue
// checked every cycle, directed scenarios followed by random bursts.
module tb_ram_burst_master;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W:0]   req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              done;
  logic              ram_CS;
  logic              ram_WE;
  logic [ADDR_W-1:0] ram_Addr;
  logic [DATA_W-1:0] ram_dataIn;
  logic [DATA_W-1:0] ram_dataOut;

  logic [DATA_W-1:0] mem [DEPTH];

  typedef struct {
    bit we;
    int addr;
    int data;
    bit last;
  } acc_t;

  acc_t exp_acc[$];
  int   rd_log[$];
  int   ref_mem[DEPTH];
  int   wdata[DEPTH];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   cs_cnt = 0;
  int   wr_cnt = 0;
  bit   chk_en = 1'b0;
  bit   done_due = 1'b0;
  bit   rd_due_v = 1'b0;
  bit   prev_rd = 1'b0;
  int   rd_due_addr = 0;
  int   rd_due_data = 0;

  always #5 Clk = ~Clk;

  ram_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .done(done),
    .ram_CS(ram_CS), .ram_WE(ram_WE), .ram_Addr(ram_Addr),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  // Synchronous single-port RAM with registered read data.
  always @(posedge Clk) begin
    if (ram_CS) begin
      if (ram_WE) mem[ram_Addr] <= ram_dataIn;
      else        ram_dataOut   <= mem[ram_Addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, want, $time);
    end
  endtask

  // Every strobe must match the head of the expected access list; reads come back
  // one cycle later with the model memory contents; done follows the last access.
  always @(negedge Clk) begin
    acc_t cur;
    if (!chk_en || !Rst_n) begin
      done_due = 1'b0;
      rd_due_v = 1'b0;
      prev_rd  = 1'b0;
    end else begin
      check("done", done, done_due);
      if (done) done_cnt++;
      done_due = 1'b0;
      check("rd_valid", rd_valid, rd_due_v);
      if (rd_valid && rd_due_v) begin
        check("rd_addr", rd_addr, rd_due_addr);
        check("rd_data", rd_data, rd_due_data);
        rd_log.push_back(int'(rd_data));
      end
      rd_due_v = 1'b0;
      if (ram_CS) begin
        cs_cnt++;
        if (exp_acc.size() == 0) begin
          check("unexpected_cs", ram_CS, 0);
        end else begin
          cur = exp_acc.pop_front();
          check("ram_WE", ram_WE, cur.we);
          check("ram_Addr", ram_Addr, cur.addr);
          if (cur.we) begin
            wr_cnt++;
            check("ram_dataIn", ram_dataIn, cur.data);
            ref_mem[cur.addr] = cur.data;
          end else begin
            rd_due_v    = 1'b1;
            rd_due_addr = cur.addr;
            rd_due_data = ref_mem[cur.addr];
          end
          if (cur.last) done_due = 1'b1;
        end
      end else if (prev_rd && exp_acc.size() != 0 && !exp_acc[0].we) begin
        check("read_back_to_back", ram_CS, 1);
      end
      prev_rd = ram_CS && !ram_WE;
    end
  end

  task automatic push_burst(input bit wr, input int a, input int len);
    acc_t e;
    for (int i = 0; i < len; i++) begin
      e.we   = wr;
      e.addr = (a + i) % DEPTH;
      e.data = wr ? wdata[i] : 0;
      e.last = (i == len - 1);
      exp_acc.push_back(e);
    end
  endtask

  task automatic start_burst(input bit wr, input int a, input int len);
    int n;
    req_write = wr;
    req_addr  = a[ADDR_W-1:0];
    req_len   = len[ADDR_W:0];
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("req_accept_wait", n < 20, 1);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    if (len == 0) done_due = 1'b1;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    check("done_wait", n < 40, 1);
    @(posedge Clk); #1;
    check("req_ready_after_done", req_ready, 1);
    check("queue_drained", exp_acc.size(), 0);
    check("done_count", done_cnt - base, 1);
  endtask

  task automatic do_write(input int a, input int len, input int gap_at, input int gap_len,
                          input bit rnd_gaps);
    int base;
    int g;
    int n;
    base = done_cnt;
    push_burst(1'b1, a, len);
    start_burst(1'b1, a, len);
    for (int i = 0; i < len; i++) begin
      if (rnd_gaps) g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      else          g = (i == gap_at) ? gap_len : 0;
      wr_valid = 1'b0;
      repeat (g) begin
        @(posedge Clk); #1;
      end
      wr_valid = 1'b1;
      wr_data  = wdata[i][DATA_W-1:0];
      n = 0;
      while (!wr_ready && n < 20) begin
        @(posedge Clk); #1;
        n++;
      end
      check("wr_ready_wait", n < 20, 1);
      @(posedge Clk); #1;
    end
    wr_valid = 1'b0;
    wait_done(base);
  endtask

  task automatic do_read(input int a, input int len);
    int base;
    base = done_cnt;
    rd_log.delete();
    push_burst(1'b0, a, len);
    start_burst(1'b0, a, len);
    wait_done(base);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=%0d want=%0d", checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int cs0;
    int wr0;
    Rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    #3;
    check("rst_ram_CS", ram_CS, 0);
    check("rst_ram_WE", ram_WE, 0);
    check("rst_ram_Addr", ram_Addr, 0);
    check("rst_ram_dataIn", ram_dataIn, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 0);
    @(posedge Clk); #1;
    Rst_n  = 1'b1;
    chk_en = 1'b1;
    check("rst_req_ready", req_ready, 1);

    // Fill every word, wr_valid held high.
    for (int i = 0; i < DEPTH; i++) wdata[i] = 30 + i;
    wr0 = wr_cnt;
    do_write(0, 8, -1, 0, 1'b0);
    check("t1_write_count", wr_cnt - wr0, 8);
    for (int i = 0; i < DEPTH; i++) check("t1_mem", mem[i], 30 + i);

    do_read(0, 5);
    check("t2_rd_count", rd_log.size(), 5);
    for (int i = 0; i < 5 && i < rd_log.size(); i++) check("t2_rd_literal", rd_log[i], 30 + i);

    // Wrapping write followed immediately by a read of the same words.
    for (int i = 0; i < 4; i++) wdata[i] = 40 + i;
    do_write(6, 4, -1, 0, 1'b0);
    do_read(6, 4);
    check("t3_rd_count", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) check("t3_rd_literal", rd_log[i], 40 + i);
    check("t3_mem0", mem[0], 42);
    check("t3_mem7", mem[7], 41);

    // Stalled write stream: two idle cycles before the third word.
    for (int i = 0; i < 4; i++) wdata[i] = int'($urandom_range(0, 255));
    wr0 = wr_cnt;
    do_write(2, 4, 2, 2, 1'b0);
    check("t4_write_count", wr_cnt - wr0, 4);

    base = done_cnt;
    cs0  = cs_cnt;
    start_burst(1'b1, 3, 0);
    wait_done(base);
    check("t5_len0_no_cs", cs_cnt - cs0, 0);

    base = done_cnt;
    rd_log.delete();
    push_burst(1'b0, 1, 4);
    start_burst(1'b0, 1, 4);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_len   = '0;
    check("t5_busy_req_ready", req_ready, 0);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    wait_done(base);

    // Reset in the third cycle of an 8-word read.
    push_burst(1'b0, 0, 8);
    start_burst(1'b0, 0, 8);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk_en = 1'b0;
    Rst_n  = 1'b0;
    #1;
    check("t6_ram_CS", ram_CS, 0);
    check("t6_rd_valid", rd_valid, 0);
    check("t6_done", done, 0);
    check("t6_ram_Addr", ram_Addr, 0);
    check("t6_wr_ready", wr_ready, 0);
    repeat (2) begin
      @(posedge Clk); #1;
      check("t6_done_in_reset", done, 0);
    end
    Rst_n = 1'b1;
    exp_acc.delete();
    chk_en = 1'b1;
    check("t6_req_ready", req_ready, 1);
    do_read(0, 3);
    check("t6_rd_count", rd_log.size(), 3);

    for (int k = 0; k < 30; k++) begin
      int wr;
      int a;
      int len;
      wr  = int'($urandom_range(0, 1));
      a   = int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(0, DEPTH));
      if (wr != 0) begin
        for (int i = 0; i < DEPTH; i++) wdata[i] = int'($urandom_range(0, 255));
        do_write(a, len, 0, 0, 1'b1);
      end else begin
        do_read(a, len);
        check("rand_rd_count", rd_log.size(), len);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
